// File: rtl/ahb_gpio_arbiter.sv
// Round-robin arbiter that lets two command requesters share one AHB-Lite GPIO slave,
// one transfer at a time, with a data-phase timeout that reports an error instead of an ack.
module ahb_gpio_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic [2*WIDTH-1:0]   addr0,
  input  logic [2*WIDTH-1:0]   addr1,
  input  logic [2*WIDTH-1:0]   wdata0,
  input  logic [2*WIDTH-1:0]   wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err0,
  output logic                 err1,
  output logic [2*WIDTH-1:0]   rdata0,
  output logic [2*WIDTH-1:0]   rdata1,
  output logic                 busy,
  output logic                 HSEL,
  output logic [1:0]           HTRANS,
  output logic [2*WIDTH-1:0]   HADDR,
  output logic                 HWRITE,
  output logic [2*WIDTH-1:0]   HWDATA,
  output logic                 HREADY,
  input  logic                 HREADYOUT,
  input  logic [2*WIDTH-1:0]   HRDATA
);

  localparam int AW = 2 * WIDTH;
  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  ADDR = 2'd1;
  localparam logic [1:0]  DATA = 2'd2;
  localparam logic [1:0]  RESP = 2'd3;
  localparam logic [15:0] TMO  = 16'(TIMEOUT);

  logic [1:0]    state;
  logic          prio;
  logic          winner;
  logic          grant;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [AW-1:0] lat_wdata;
  logic          ack_flag;
  logic          err_flag;
  logic [15:0]   cnt;
  logic [15:0]   cnt_inc;

  // prio names the requester that wins a tie: the one that did not win last time
  always_comb begin
    grant   = (req0 && req1) ? prio : req1;
    cnt_inc = cnt + 16'd1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      prio      <= 1'b0;
      winner    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack_flag  <= 1'b0;
      err_flag  <= 1'b0;
      cnt       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner    <= grant;
            lat_wr    <= grant ? wr1 : wr0;
            lat_addr  <= grant ? addr1 : addr0;
            lat_wdata <= grant ? wdata1 : wdata0;
            state     <= ADDR;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          if (HREADYOUT) begin
            if (!lat_wr) begin
              if (winner) rdata1 <= HRDATA;
              else        rdata0 <= HRDATA;
            end
            ack_flag <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TMO) begin
              err_flag <= 1'b1;
              state    <= RESP;
            end
          end
        end
        default: begin
          prio     <= ~winner;
          cnt      <= '0;
          ack_flag <= 1'b0;
          err_flag <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // bus and response outputs decode directly from the state and the latched command
  always_comb begin
    HSEL   = (state == ADDR);
    HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
    HADDR  = lat_addr;
    HWRITE = lat_wr;
    HWDATA = (state == DATA && lat_wr) ? lat_wdata : '0;
    HREADY = HREADYOUT;
    busy   = (state != IDLE);
    ack0   = (state == RESP) && ack_flag && !winner;
    ack1   = (state == RESP) && ack_flag &&  winner;
    err0   = (state == RESP) && err_flag && !winner;
    err1   = (state == RESP) && err_flag &&  winner;
  end

endmodule

// File: tb/tb_ahb_gpio_arbiter.sv
// Bench for ahb_gpio_arbiter: directed commands push expected bus and response records,
// and an independent monitor checks them as the address phases and ack/err pulses appear.
module tb_ahb_gpio_arbiter;
  localparam int WIDTH = 16;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        busy, hsel, hwrite, hready;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        hreadyout;
  logic [31:0] hrdata;

  always #5 clk = ~clk;

  ahb_gpio_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .HCLK(clk), .HRESET(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .HSEL(hsel), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout), .HRDATA(hrdata)
  );

  typedef struct { int id; bit is_err; logic [31:0] rd0; logic [31:0] rd1; } resp_t;
  typedef struct { logic [31:0] addr; bit wr; logic [31:0] wdata; } addr_t;

  resp_t       resp_q[$];
  addr_t       addr_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] mdl_rd0 = '0;
  logic [31:0] mdl_rd1 = '0;
  int          wait_cfg = 0;
  logic [31:0] rd_cfg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_addr(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    addr_q.push_back(addr_t'{addr: a, wr: wr, wdata: wr ? wd : 32'h0});
  endtask

  task automatic expect_xfer(input int id, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input bit tmo, input logic [31:0] rd);
    expect_addr(wr, a, wd);
    if (!wr && !tmo) begin
      if (id == 0) mdl_rd0 = rd;
      else         mdl_rd1 = rd;
    end
    resp_q.push_back(resp_t'{id: id, is_err: tmo, rd0: mdl_rd0, rd1: mdl_rd1});
  endtask

  // Cycles from now until any ack/err is visible; a bounded wait
  task automatic wait_any(input string name, output int n);
    n = 0;
    forever begin
      tick();
      n++;
      if (ack0 | ack1 | err0 | err1) break;
      if (n >= 40) begin
        checks++;
        fails++;
        $display("FAIL %s: no ack/err within %0d cycles, expected one", name, n);
        break;
      end
    end
  endtask

  // Slave model: after each address phase, hold HREADYOUT low for wait_cfg data-phase cycles
  int wl = 0;
  always @(posedge clk) begin
    #1;
    if (hsel && htrans == 2'b10) begin
      wl = wait_cfg;
    end else begin
      hreadyout = (wl == 0);
      hrdata    = (wl == 0) ? rd_cfg : 32'hDEAD_BEEF;
      if (wl > 0) wl--;
    end
  end

  // Monitor: consumes the expectation queues as the DUT presents bus phases and responses
  bit    chk_wdata = 1'b0;
  addr_t cur;
  resp_t r;
  always @(negedge clk) begin
    if (chk_wdata) begin
      check("hwdata", hwdata, cur.wdata);
      chk_wdata = 1'b0;
    end
    if (htrans == 2'b10) begin
      if (addr_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_addr_phase: HADDR %h seen, expected no transfer", haddr);
      end else begin
        cur = addr_q.pop_front();
        check("haddr", haddr, cur.addr);
        check("hwrite", 32'(hwrite), 32'(cur.wr));
        check("hsel_in_addr", 32'(hsel), 32'd1);
        chk_wdata = 1'b1;
      end
    end
    if (ack0 | ack1 | err0 | err1) begin
      check("single_response", 32'($countones({ack0, ack1, err0, err1})), 32'd1);
      if (resp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_response: ack=%b%b err=%b%b, expected none", ack1, ack0, err1, err0);
      end else begin
        r = resp_q.pop_front();
        check("resp_id", 32'(ack1 | err1), 32'(r.id));
        check("resp_err", 32'(err0 | err1), 32'(r.is_err));
        check("rdata0", rdata0, r.rd0);
        check("rdata1", rdata1, r.rd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    hreadyout = 1'b1; hrdata = '0;

    // Reset held with a pending write request, then single zero-wait write
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0004; wdata0 = 32'h0000_A5A5;
    repeat (3) begin
      tick();
      check("rst_htrans", 32'(htrans), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hsel", 32'(hsel), 32'd0);
    end
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    expect_xfer(0, 1'b1, 32'h4, 32'h0000_A5A5, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    check("wr_cycle1_htrans", 32'(htrans), 32'h2);
    check("wr_cycle1_busy", 32'(busy), 32'd1);
    tick();
    check("wr_cycle2_hwdata", hwdata, 32'h0000_A5A5);
    check("wr_cycle2_no_ack", 32'(ack0), 32'd0);
    tick();
    check("wr_cycle3_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    tick();
    check("wr_cycle4_ack0_low", 32'(ack0), 32'd0);

    // Read from requester 1 with three wait states
    wait_cfg = 3; rd_cfg = 32'h0000_1234;
    wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'hFFFF_FFFF;
    expect_xfer(1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0000_1234);
    req1 = 1'b1;
    wait_any("read_wait", n);
    check("read_latency", 32'(n), 32'd6);
    req1 = 1'b0;
    tick();

    // Contention from reset: grants alternate 0,1,0,1 four cycles apart
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_rd0 = '0; mdl_rd1 = '0;
    wait_cfg = 0; rd_cfg = 32'hCAFE_0001;
    wr0 = 1'b0; addr0 = 32'h8;
    wr1 = 1'b1; addr1 = 32'hC; wdata1 = 32'h1111_2222;
    expect_xfer(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFE_0001);
    expect_xfer(1, 1'b1, 32'hC, 32'h1111_2222, 1'b0, 32'h0);
    expect_xfer(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFE_0001);
    expect_xfer(1, 1'b1, 32'hC, 32'h1111_2222, 1'b0, 32'h0);
    req0 = 1'b1; req1 = 1'b1;
    wait_any("cont_first", n);
    check("cont_first_latency", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_any("cont_next", n);
      check("cont_interval", 32'(n), 32'd4);
      if (i == 1) req0 = 1'b0;
      if (i == 2) req1 = 1'b0;
    end
    tick();
    tick();

    // Timeout after four wait cycles, then a normal transfer
    wait_cfg = 1000;
    wr0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h0000_0055;
    expect_xfer(0, 1'b1, 32'hC, 32'h0000_0055, 1'b1, 32'h0);
    req0 = 1'b1;
    wait_any("timeout", n);
    check("timeout_latency", 32'(n), 32'd6);
    check("timeout_err0", 32'(err0), 32'd1);
    req0 = 1'b0;
    tick();
    wait_cfg = 1; rd_cfg = 32'h0000_7777;
    wr0 = 1'b0; addr0 = 32'h10;
    expect_xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_7777);
    req0 = 1'b1;
    wait_any("after_timeout", n);
    check("after_timeout_latency", 32'(n), 32'd4);
    req0 = 1'b0;
    tick();

    // Reset during the data phase aborts silently and restores requester 0 priority
    wait_cfg = 1000;
    wr1 = 1'b0; addr1 = 32'h20;
    expect_addr(1'b0, 32'h20, 32'h0);
    req1 = 1'b1;
    tick();
    tick();
    rst = 1'b1; req1 = 1'b0;
    tick();
    check("mr_hsel", 32'(hsel), 32'd0);
    check("mr_htrans", 32'(htrans), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_no_resp", 32'(ack0 | ack1 | err0 | err1), 32'd0);
    check("mr_rdata0", rdata0, 32'd0);
    rst = 1'b0;
    mdl_rd0 = '0; mdl_rd1 = '0;
    wait_cfg = 0;
    tick();
    wr0 = 1'b1; addr0 = 32'h24; wdata0 = 32'h0000_BEEF;
    wr1 = 1'b0; addr1 = 32'h28;
    expect_xfer(0, 1'b1, 32'h24, 32'h0000_BEEF, 1'b0, 32'h0);
    req0 = 1'b1; req1 = 1'b1;
    wait_any("mr_tie", n);
    check("mr_tie_latency", 32'(n), 32'd3);
    check("mr_tie_winner0", 32'(ack0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;

    repeat (5) tick();
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
